lab2_rr_arbiter_32: RTL and testbench

// Round-robin arbiter over 32 requesters; the upstream stage of the 5x32 decoder.

---
 rtl/lab2_rr_arbiter_32.sv | 71 +++++++
 tb/tb_lab2_rr_arbiter_32.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lab2_rr_arbiter_32.sv
// Round-robin arbiter over 32 requesters feeding the 5x32 decoder's A/enable inputs.
// Grants stay locked until acked; a watchdog revokes grants that are never acked.
module lab2_rr_arbiter_32 #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        ack,
    output logic [4:0]  A,
    output logic        enable,
    output logic        timeout_err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [4:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rot;
    logic [4:0]       off;
    logic [4:0]       winner;

    // Rotate so that bit 0 is the search start, then take the lowest set bit.
    always_comb begin
        rot = 32'({req, req} >> ptr);
        off = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (rot[i-1]) off = 5'(i - 1);
        end
        winner = ptr + off;
    end

    assign enable = (state == GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            A           <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        A     <= winner;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                default: begin
                    if (ack) begin
                        ptr   <= A + 5'd1;
                        state <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        ptr         <= A + 5'd1;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_rr_arbiter_32.sv
// Randomised and directed bench for lab2_rr_arbiter_32 with a transaction-level
// reference model; expected grant indices flow through a scoreboard queue.
module tb_lab2_rr_arbiter_32;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic        ack = 1'b0;
    logic [4:0]  A;
    logic        enable;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    lab2_rr_arbiter_32 #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .A(A), .enable(enable), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: a grant is a transaction with an owner and an age in cycles.
    int m_ptr, m_idx, m_age;
    bit m_busy, m_terr;
    int sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_idx = 0; m_age = 0; m_busy = 0; m_terr = 0;
            sb.delete();
        end else begin
            m_terr = 0;
            if (!m_busy) begin
                if (req != 0) begin
                    for (int k = 0; k < 32; k++) begin
                        if (req[(m_ptr + k) % 32]) begin
                            m_idx = (m_ptr + k) % 32;
                            break;
                        end
                    end
                    m_busy = 1;
                    m_age  = 1;
                    sb.push_back(m_idx);
                end
            end else if (ack) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % 32;
            end else if (m_age == TIMEOUT) begin
                m_busy = 0;
                m_terr = 1;
                m_ptr  = (m_idx + 1) % 32;
            end else begin
                m_age++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle enable/timeout_err, grant index popped on each new grant.
    bit prev_en = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("enable", int'(enable), int'(m_busy));
            check("timeout_err", int'(timeout_err), int'(m_terr));
            if (enable && !prev_en) begin
                if (sb.size() == 0) begin
                    check("grant_without_expectation", 1, 0);
                end else begin
                    check("grant_A", int'(A), sb.pop_front());
                end
            end
            prev_en = enable;
        end else begin
            prev_en = 0;
        end
    end

    task automatic wait_en();
        int k = 0;
        while (!enable && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!enable) check("wait_enable_timeout", 0, 1);
    endtask

    // Waits for a grant, then asserts ack during its hold-th enable cycle.
    task automatic do_grant(input int hold);
        wait_en();
        repeat (hold - 1) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int n;
        // T1: reset held with everyone requesting
        rst_n = 1'b0;
        req   = '1;
        repeat (3) begin
            @(negedge clk);
            check("rst_A", int'(A), 0);
            check("rst_enable", int'(enable), 0);
            check("rst_timeout_err", int'(timeout_err), 0);
        end

        // T2: single requester, ack in the second enable cycle, then again from ptr=1
        req   = 32'h0000_0001;
        rst_n = 1'b1;
        do_grant(2);
        check("t2_idle_after_ack", int'(enable), 0);
        do_grant(1);

        // T3: wrap from ptr=1 to client 31, then back to 0
        req = 32'h8000_0001;
        do_grant(1);
        do_grant(1);

        // T4: full rotation with immediate acks
        req = '1;
        repeat (33) do_grant(1);

        // T5: watchdog on client 5
        req = 32'h0000_0020;
        wait_en();
        n = 0;
        while (enable && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("t5_enable_cycles", n, TIMEOUT);
        check("t5_timeout_pulse", int'(timeout_err), 1);
        req = 32'h0000_0070;
        @(negedge clk);
        check("t5_pulse_one_cycle", int'(timeout_err), 0);
        do_grant(TIMEOUT);
        check("t5_ack_wins", int'(timeout_err), 0);
        req = '0;
        repeat (2) @(negedge clk);

        // Random traffic: random requests, acks and stalls
        for (int t = 0; t < 400; t++) begin
            req = ($urandom_range(0, 3) == 0) ? 32'($urandom) & 32'($urandom) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) req = '0;
            ack = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        ack = 1'b0;
        req = '0;
        repeat (TIMEOUT + 2) @(negedge clk);

        // T6: asynchronous reset in the middle of a grant to client 9
        req = 32'h0000_0200;
        wait_en();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_enable", int'(enable), 0);
        check("t6_async_A", int'(A), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_grant(1);
        req = '0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
